// File: rtl/clb_pkg.sv
// Shared constants and helpers for the CLB-style adder.
package clb_pkg;

  localparam int CLB_WIDTH = 32;

  // Operand field offsets inside the packed din word (B low, A high).
  localparam int B_LSB = 0;
  localparam int A_LSB = CLB_WIDTH;

  function automatic int sum_width(input int width);
    return width + 1;
  endfunction

  function automatic int a_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/clb_fa.sv
// One-bit full adder expressed as a pair of 3-input LUT truth tables.
module clb_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // LUT init words indexed by {a, b, cin}.
  localparam logic [7:0] SUM_LUT  = 8'b1001_0110;
  localparam logic [7:0] COUT_LUT = 8'b1110_1000;

  logic [2:0] sel;

  assign sel  = {a, b, cin};
  assign sum  = SUM_LUT[sel];
  assign cout = COUT_LUT[sel];

endmodule

// File: rtl/clb_add.sv
// Pipelined unsigned adder: ripple chain of LUT full adders feeding a
// single-entry valid/ready output register.
module clb_add
  import clb_pkg::*;
#(
  parameter int WIDTH = CLB_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        rdy,
  input  logic                        send_data,
  input  logic [2*WIDTH-1:0]          din,
  input  logic                        divld,
  output logic [sum_width(WIDTH)-1:0] dout,
  output logic                        dovld
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   carry;
  logic             accept;
  logic             consume;

  assign op_a     = din[a_lsb(WIDTH) +: WIDTH];
  assign op_b     = din[B_LSB +: WIDTH];
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    clb_fa u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (carry[i]),
      .sum  (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  assign rdy     = rst & en & (~dovld | send_data);
  assign accept  = divld & rdy;
  assign consume = dovld & send_data & en;

  // A same-cycle accept overrides the consume so results can stream every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout  <= '0;
      dovld <= 1'b0;
    end else if (accept) begin
      dout  <= {carry[WIDTH], sum_bits};
      dovld <= 1'b1;
    end else if (consume) begin
      dovld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clb_add.sv
// Directed self-checking bench for clb_add at the default 32-bit width.
module tb_clb_add;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic        send_data;
  logic [63:0] din;
  logic        divld;
  logic [32:0] dout;
  logic        dovld;

  int total;
  int bad;

  clb_add #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .send_data (send_data),
    .din       (din),
    .divld     (divld),
    .dout      (dout),
    .dovld     (dovld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; send_data = 1'b1; divld = 1'b1;
    din = {32'd1, 32'd1};
    step();
    step();
    total++;
    if (dout !== 33'h0) begin bad++; $display("FAIL reset_dout actual=%h required=%h", dout, 33'h0); end
    total++;
    if (dovld !== 1'b0) begin bad++; $display("FAIL reset_dovld actual=%b required=0", dovld); end
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy actual=%b required=0", rdy); end
    divld = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    din = {32'h000000D0, 32'h0000000E}; divld = 1'b1;
    step();
    total++;
    if (dout !== 33'h0000000DE) begin bad++; $display("FAIL basic_dout actual=%h required=%h", dout, 33'h0DE); end
    total++;
    if (dovld !== 1'b1) begin bad++; $display("FAIL basic_dovld actual=%b required=1", dovld); end
    divld = 1'b0;
    step();
    total++;
    if (dovld !== 1'b0 || dout !== 33'h0DE) begin
      bad++; $display("FAIL basic_consume actual=%b/%h required=0/%h", dovld, dout, 33'h0DE);
    end
  endtask

  task automatic test_carry();
    din = {32'hFFFFFFFF, 32'h00000001}; divld = 1'b1;
    step();
    total++;
    if (dout !== 33'h100000000) begin bad++; $display("FAIL carry_one actual=%h required=%h", dout, 33'h100000000); end
    din = {32'hFFFFFFFF, 32'hFFFFFFFF};
    step();
    total++;
    if (dout !== 33'h1FFFFFFFE || dovld !== 1'b1) begin
      bad++; $display("FAIL carry_ones actual=%h/%b required=%h/1", dout, dovld, 33'h1FFFFFFFE);
    end
    divld = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    send_data = 1'b0;
    din = {32'd5, 32'd7}; divld = 1'b1;
    step();
    total++;
    if (dout !== 33'hC || dovld !== 1'b1) begin
      bad++; $display("FAIL bp_first actual=%h/%b required=%h/1", dout, dovld, 33'hC);
    end
    din = {32'd9, 32'd1};
    #1;
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_low actual=%b required=0", rdy); end
    step();
    total++;
    if (dout !== 33'hC || dovld !== 1'b1) begin
      bad++; $display("FAIL bp_hold actual=%h/%b required=%h/1", dout, dovld, 33'hC);
    end
    send_data = 1'b1;
    #1;
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_high actual=%b required=1", rdy); end
    step();
    total++;
    if (dout !== 33'hA || dovld !== 1'b1) begin
      bad++; $display("FAIL bp_release actual=%h/%b required=%h/1", dout, dovld, 33'hA);
    end
    divld = 1'b0;
    step();
    total++;
    if (dovld !== 1'b0) begin bad++; $display("FAIL bp_drain actual=%b required=0", dovld); end
  endtask

  task automatic test_streaming();
    logic [31:0] a_vec [3] = '{32'd1, 32'd3, 32'd5};
    logic [31:0] b_vec [3] = '{32'd2, 32'd4, 32'd6};
    logic [32:0] exp_vec [3] = '{33'h3, 33'h7, 33'hB};
    send_data = 1'b1;
    divld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = {a_vec[i], b_vec[i]};
      step();
      total++;
      if (dout !== exp_vec[i] || dovld !== 1'b1) begin
        bad++; $display("FAIL stream_%0d actual=%h/%b required=%h/1", i, dout, dovld, exp_vec[i]);
      end
    end
    divld = 1'b0;
    step();
    total++;
    if (dovld !== 1'b0) begin bad++; $display("FAIL stream_drain actual=%b required=0", dovld); end
  endtask

  task automatic test_enable();
    send_data = 1'b0;
    din = {32'd2, 32'd2}; divld = 1'b1;
    step();
    en = 1'b0; send_data = 1'b1;
    din = {32'd8, 32'd8};
    #1;
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL en_rdy actual=%b required=0", rdy); end
    step();
    step();
    total++;
    if (dout !== 33'h4 || dovld !== 1'b1) begin
      bad++; $display("FAIL en_freeze actual=%h/%b required=%h/1", dout, dovld, 33'h4);
    end
    en = 1'b1;
    #1;
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL en_rdy_restore actual=%b required=1", rdy); end
    step();
    total++;
    if (dout !== 33'h10 || dovld !== 1'b1) begin
      bad++; $display("FAIL en_resume actual=%h/%b required=%h/1", dout, dovld, 33'h10);
    end
    divld = 1'b0;
  endtask

  task automatic test_async_reset();
    // dovld is still 1 from the enable scenario; stall so it stays pending.
    send_data = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (dout !== 33'h0 || dovld !== 1'b0 || rdy !== 1'b0) begin
      bad++; $display("FAIL async_rst actual=%h/%b/%b required=0/0/0", dout, dovld, rdy);
    end
    step();
    rst = 1'b1; send_data = 1'b1;
    din = {32'h10, 32'h20}; divld = 1'b1;
    step();
    total++;
    if (dout !== 33'h30 || dovld !== 1'b1) begin
      bad++; $display("FAIL async_recover actual=%h/%b required=%h/1", dout, dovld, 33'h30);
    end
    divld = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; en = 1'b0; send_data = 1'b0; divld = 1'b0; din = '0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_streaming();
    test_enable();
    test_async_reset();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
